// File: rtl/tc_accum_writer.sv
// Timer/counter accumulator bank: owns acc/preset for every channel, takes processor
// writes over a req/ack handshake and advances each channel as a timer or a counter.
module tc_accum_writer #(
    parameter int ACC_LEN  = 8,
    parameter int NUM      = 8,
    parameter int ADDR_LEN = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tcAccumWrite,
    input  logic [ADDR_LEN-1:0]    tcAddr,
    input  logic                   tcWriteSel,
    input  logic [ACC_LEN-1:0]     tcWriteData,
    output logic                   tcWriteAck,
    input  logic [NUM-1:0]         tcType,
    input  logic [NUM-1:0]         tcEnable,
    input  logic                   tcTick,
    output logic [NUM-1:0]         tcDone,
    output logic [ACC_LEN*NUM-1:0] tcAccumOut
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMMIT  = 2'd1,
        ACK     = 2'd2,
        WAITLOW = 2'd3
    } wrState_t;

    wrState_t            stateReg;
    wrState_t            stateNext;
    logic                ackReg;
    logic                captureEn;
    logic                commitEn;
    logic [ADDR_LEN-1:0] addrReg;
    logic                selReg;
    logic [ACC_LEN-1:0]  dataReg;

    // Ack is a flop loaded with "next state is ACK", so it is high exactly while in ACK
    // and never glitches on state-bit transitions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg <= IDLE;
            ackReg   <= 1'b0;
        end else begin
            stateReg <= stateNext;
            ackReg   <= (stateNext == ACK);
        end
    end

    always_comb begin
        stateNext = stateReg;
        captureEn = 1'b0;
        commitEn  = 1'b0;
        case (stateReg)
            IDLE: begin
                if (tcAccumWrite) begin
                    captureEn = 1'b1;
                    stateNext = COMMIT;
                end
            end
            COMMIT: begin
                commitEn  = 1'b1;
                stateNext = ACK;
            end
            ACK: begin
                stateNext = WAITLOW;
            end
            WAITLOW: begin
                if (!tcAccumWrite) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign tcWriteAck = ackReg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addrReg <= '0;
            selReg  <= 1'b0;
            dataReg <= '0;
        end else if (captureEn) begin
            addrReg <= tcAddr;
            selReg  <= tcWriteSel;
            dataReg <= tcWriteData;
        end
    end

    for (genvar gi = 0; gi < NUM; gi++) begin : gCh
        logic [ACC_LEN-1:0] accReg;
        logic [ACC_LEN-1:0] presetReg;
        logic               enPrevReg;
        logic               writeHit;
        logic               belowPreset;
        logic               countEvent;

        // Out-of-range addresses match no channel, so the write is silently dropped.
        assign writeHit    = commitEn && (32'(addrReg) == gi);
        assign belowPreset = (accReg < presetReg);
        assign countEvent  = tcType[gi] ? (tcEnable[gi] && tcTick)
                                        : (tcEnable[gi] && !enPrevReg);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                accReg    <= '0;
                presetReg <= '1;
                enPrevReg <= 1'b0;
            end else begin
                enPrevReg <= tcEnable[gi];
                // A processor write takes priority over any count/clear in the same cycle.
                if (writeHit && !selReg) begin
                    accReg <= dataReg;
                end else if (tcType[gi] && !tcEnable[gi]) begin
                    accReg <= '0;
                end else if (countEvent && belowPreset) begin
                    accReg <= accReg + 1'b1;
                end
                if (writeHit && selReg) begin
                    presetReg <= dataReg;
                end
            end
        end

        assign tcDone[gi]                             = !belowPreset;
        assign tcAccumOut[ACC_LEN*gi +: ACC_LEN]      = accReg;
    end

endmodule

// File: tb/tb_tc_accum_writer.sv
// Self-checking bench for tc_accum_writer: directed handshake/timer/counter steps
// followed by randomized traffic compared against a per-channel behavioural model.
module tb_tc_accum_writer;

    localparam int ACC = 8;
    localparam int N   = 8;
    localparam int AW  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             tcAccumWrite;
    logic [AW-1:0]    tcAddr;
    logic             tcWriteSel;
    logic [ACC-1:0]   tcWriteData;
    logic             tcWriteAck;
    logic [N-1:0]     tcType;
    logic [N-1:0]     tcEnable;
    logic             tcTick;
    logic [N-1:0]     tcDone;
    logic [ACC*N-1:0] tcAccumOut;

    tc_accum_writer #(.ACC_LEN(ACC), .NUM(N), .ADDR_LEN(AW)) dut (
        .clk(clk),
        .reset(reset),
        .tcAccumWrite(tcAccumWrite),
        .tcAddr(tcAddr),
        .tcWriteSel(tcWriteSel),
        .tcWriteData(tcWriteData),
        .tcWriteAck(tcWriteAck),
        .tcType(tcType),
        .tcEnable(tcEnable),
        .tcTick(tcTick),
        .tcDone(tcDone),
        .tcAccumOut(tcAccumOut)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit randomIo = 1'b0;

    // Reference model: what each channel should hold, from the behavioural rules.
    int mAcc  [N];
    int mPre  [N];
    bit mPrev [N];

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            mAcc[i]  = 0;
            mPre[i]  = 255;
            mPrev[i] = 1'b0;
        end
    endtask

    function automatic logic [ACC*N-1:0] expOut();
        logic [ACC*N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[ACC*i +: ACC] = mAcc[i][ACC-1:0];
        return v;
    endfunction

    function automatic logic [N-1:0] expDone();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = (mAcc[i] >= mPre[i]);
        return v;
    endfunction

    function automatic logic [ACC-1:0] accOf(input int ch);
        return tcAccumOut[ACC*ch +: ACC];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample inputs, advance the model at the edge, check outputs 1ns later.
    task automatic cycle(input bit doW, input int ch, input bit sel, input int data, input bit expAck);
        logic [N-1:0] en;
        logic [N-1:0] ty;
        logic         tk;
        if (randomIo) begin
            tcTick   = 1'($urandom_range(0, 1));
            tcEnable = N'($urandom | $urandom);
            if ($urandom_range(0, 15) == 0) tcType = N'($urandom);
        end
        en = tcEnable;
        ty = tcType;
        tk = tcTick;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            bit hit;
            bit evt;
            hit = doW && (ch == i);
            evt = ty[i] ? (en[i] && tk) : (en[i] && !mPrev[i]);
            if (hit && !sel)               mAcc[i] = data;
            else if (ty[i] && !en[i])      mAcc[i] = 0;
            else if (evt && mAcc[i] < mPre[i]) mAcc[i] = mAcc[i] + 1;
            if (hit && sel)                mPre[i] = data;
            mPrev[i] = en[i];
        end
        #1;
        check("accumOut", 64'(tcAccumOut), 64'(expOut()));
        check("done", 64'(tcDone), 64'(expDone()));
        check("ack", 64'(tcWriteAck), 64'(expAck));
        $display("cycle t=%0t wr=%0d ch=%0d sel=%0d data=%0h ack=%0d out=%h done=%b",
                 $time, doW, ch, sel, data, tcWriteAck, tcAccumOut, tcDone);
    endtask

    task automatic writeOp(input int addr, input bit sel, input int data, input int hold);
        tcAccumWrite = 1'b1;
        tcAddr       = addr[AW-1:0];
        tcWriteSel   = sel;
        tcWriteData  = data[ACC-1:0];
        cycle(1'b0, 0, 1'b0, 0, 1'b0);           // request captured
        tcWriteData  = ~data[ACC-1:0];            // must not matter after capture
        cycle(1'b1, addr, sel, data, 1'b1);       // commit, ack visible
        cycle(1'b0, 0, 1'b0, 0, 1'b0);
        for (int h = 0; h < hold; h++) cycle(1'b0, 0, 1'b0, 0, 1'b0);
        tcAccumWrite = 1'b0;
        cycle(1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        reset        = 1'b1;
        tcAccumWrite = 1'b0;
        tcAddr       = '0;
        tcWriteSel   = 1'b0;
        tcWriteData  = '0;
        tcType       = 8'h08;
        tcEnable     = '0;
        tcTick       = 1'b0;
        modelReset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", 64'(tcAccumOut), 64'd0);
        check("rst_done", 64'(tcDone), 64'd0);
        check("rst_ack", 64'(tcWriteAck), 64'd0);
        reset = 1'b0;
        repeat (2) cycle(1'b0, 0, 1'b0, 0, 1'b0);

        // Preset write ch3 = 5
        writeOp(3, 1'b1, 5, 0);
        check("ch3_done_after_preset", 64'(tcDone[3]), 64'd0);

        // Timer ch3: 7 ticks with enable held
        tcEnable[3] = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tcTick = 1'b1;
            cycle(1'b0, 0, 1'b0, 0, 1'b0);
            tcTick = 1'b0;
            check("timer_acc", 64'(accOf(3)), 64'((t < 5) ? t : 5));
            if (t == 5) check("timer_done5", 64'(tcDone[3]), 64'd1);
            cycle(1'b0, 0, 1'b0, 0, 1'b0);
        end
        tcEnable[3] = 1'b0;
        cycle(1'b0, 0, 1'b0, 0, 1'b0);
        check("timer_clear_acc", 64'(accOf(3)), 64'd0);
        check("timer_clear_done", 64'(tcDone[3]), 64'd0);

        // Counter ch0, preset 3, 5 long enable pulses
        writeOp(0, 1'b1, 3, 0);
        for (int p = 1; p <= 5; p++) begin
            tcEnable[0] = 1'b1;
            repeat (3) cycle(1'b0, 0, 1'b0, 0, 1'b0);
            check("counter_acc", 64'(accOf(0)), 64'((p < 3) ? p : 3));
            tcEnable[0] = 1'b0;
            cycle(1'b0, 0, 1'b0, 0, 1'b0);
        end

        // Write acc ch0=2 coinciding with counted edges on ch0 and ch1
        writeOp(0, 1'b1, 10, 0);
        tcAccumWrite = 1'b1;
        tcAddr       = 4'd0;
        tcWriteSel   = 1'b0;
        tcWriteData  = 8'd2;
        cycle(1'b0, 0, 1'b0, 0, 1'b0);
        tcEnable[0] = 1'b1;
        tcEnable[1] = 1'b1;
        cycle(1'b1, 0, 1'b0, 2, 1'b1);
        check("collide_ch0", 64'(accOf(0)), 64'd2);
        check("collide_ch1", 64'(accOf(1)), 64'd1);
        tcAccumWrite = 1'b0;
        repeat (2) cycle(1'b0, 0, 1'b0, 0, 1'b0);
        tcEnable = '0;
        cycle(1'b0, 0, 1'b0, 0, 1'b0);

        // Request held high after ack; then an out-of-range address
        writeOp(5, 1'b0, 7, 4);
        check("held_ch5", 64'(accOf(5)), 64'd7);
        writeOp(9, 1'b0, 8'h55, 0);

        // Reset during COMMIT of acc ch2 = 0xAA
        tcAccumWrite = 1'b1;
        tcAddr       = 4'd2;
        tcWriteSel   = 1'b0;
        tcWriteData  = 8'hAA;
        cycle(1'b0, 0, 1'b0, 0, 1'b0);
        reset = 1'b1;
        modelReset();
        #1;
        check("midrst_out", 64'(tcAccumOut), 64'd0);
        check("midrst_ack", 64'(tcWriteAck), 64'd0);
        @(posedge clk);
        #1;
        check("midrst_ack2", 64'(tcWriteAck), 64'd0);
        check("midrst_ch2", 64'(accOf(2)), 64'd0);
        reset        = 1'b0;
        tcAccumWrite = 1'b0;
        repeat (2) cycle(1'b0, 0, 1'b0, 0, 1'b0);
        writeOp(2, 1'b0, 8'h11, 0);
        check("post_rst_ch2", 64'(accOf(2)), 64'h11);

        // Randomized traffic
        randomIo = 1'b1;
        for (int k = 0; k < 60; k++) begin
            int a;
            int d;
            a = $urandom_range(0, 9);
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
            writeOp(a, 1'($urandom_range(0, 1)), d, $urandom_range(0, 2));
            repeat ($urandom_range(0, 4)) cycle(1'b0, 0, 1'b0, 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
